// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input vector of a truth table, samples the DUT output after a settle delay and scores it
module truth_table_sweeper #(
  parameter int N_IN = 3,
  parameter int SETTLE_W = 2,
  localparam int T = 2 ** N_IN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [T-1:0]        expected,
  input  logic [SETTLE_W-1:0] settle,
  input  logic                dut_y,
  output logic [N_IN-1:0]     abc,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [T-1:0]        captured,
  output logic [T-1:0]        fail_mask,
  output logic [N_IN:0]       err_count
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  logic [1:0] state;
  logic [N_IN-1:0] idx;
  logic [SETTLE_W-1:0] cnt, settle_l;
  logic [T-1:0] exp_l;
  logic mis;
  assign mis = dut_y ^ exp_l[idx];
  // sweep sequencer: abort beats everything except reset, and an aborted sample writes nothing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx <= '0;
      cnt <= '0;
      settle_l <= '0;
      exp_l <= '0;
      abc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      captured <= '0;
      fail_mask <= '0;
      err_count <= '0;
    end else if (state != ST_IDLE && abort) begin
      state <= ST_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            exp_l <= expected;
            settle_l <= settle;
            idx <= '0;
            abc <= '0;
            cnt <= settle;
            captured <= '0;
            fail_mask <= '0;
            err_count <= '0;
            pass <= 1'b0;
            busy <= 1'b1;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_SAMPLE;
          else cnt <= cnt - SETTLE_W'(1);
        end
        ST_SAMPLE: begin
          captured[idx] <= dut_y;
          fail_mask[idx] <= mis;
          err_count <= err_count + (N_IN + 1)'(mis);
          if (idx == N_IN'(T - 1)) state <= ST_DONE;
          else begin
            idx <= idx + N_IN'(1);
            abc <= abc + N_IN'(1);
            cnt <= settle_l;
            state <= ST_WAIT;
          end
        end
        default: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= (fail_mask == '0);
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter: N_IN, 3, number of DUT inputs; table depth T = 2**N_IN.
REQ-002 Parameter: SETTLE_W, 2, width of the settle-delay field.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 start  in  1  request a sweep; sampled only in IDLE.
REQ-007 abort  in  1  terminate a sweep in progress.
REQ-008 expected  in  T  golden output column; bit i is the expected Y for input index i.
REQ-009 settle  in  SETTLE_W  extra wait cycles between driving a vector and sampling it.
REQ-010 dut_y  in  1  output of the mux-based truth-table implementation under control.
REQ-011 abc  out  N_IN  DUT input vector {A,B,C}; A is the MSB.
REQ-012 busy  out  1  high while a sweep is in progress.
REQ-013 done  out  1  one-cycle pulse when a sweep completes normally.
REQ-014 pass  out  1  high when the last completed sweep had zero mismatches.
REQ-015 captured  out  T  sampled dut_y values; bit i corresponds to index i.
REQ-016 fail_mask  out  T  bit i = captured[i] XOR expected[i].
REQ-017 err_count  out  N_IN+1  number of mismatches, 0..T.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT, SAMPLE and DONE, all outputs registered.
REQ-019 IDLE with start=1 and abort=0 SHALL latch expected and settle internally at that edge.
REQ-020 The same IDLE start edge SHALL set idx=0, abc=0 and cnt=settle.
REQ-021 The same IDLE start edge SHALL clear captured, fail_mask, err_count and pass, set busy=1, and go to WAIT.
REQ-022 WAIT: if cnt=0 the FSM SHALL go to SAMPLE, else decrement cnt; abc is held.
REQ-023 SAMPLE SHALL write captured[idx]=dut_y and fail_mask[idx]=dut_y^exp_latched[idx].
REQ-024 SAMPLE SHALL increment err_count on a mismatch.
REQ-025 SAMPLE with idx<T-1 SHALL increment idx and abc, reload cnt from the latched settle, and go to WAIT.
REQ-026 SAMPLE with idx=T-1 SHALL go to DONE.
REQ-027 DONE SHALL, for exactly one cycle, set done=1, busy=0 and pass=(fail_mask==0), then go to IDLE; done returns to 0 on the following edge.
REQ-028 Each vector SHALL occupy settle+2 cycles, and abc SHALL be stable for all of them.
REQ-029 With start at edge 0, DONE SHALL be entered at edge 1+T*(settle+2); this is edge 17 for T=8 and settle=0.
REQ-030 start while not in IDLE SHALL be ignored.
REQ-031 Changes on expected or settle during a sweep SHALL have no effect.
REQ-032 abort in WAIT, SAMPLE or DONE SHALL force IDLE at the next edge with busy=0, done=0 and pass=0.
REQ-033 After abort, captured, fail_mask and err_count SHALL keep their partial values.
REQ-034 An abort-edge SAMPLE SHALL NOT write captured, fail_mask or err_count.
REQ-035 start and abort together in IDLE SHALL leave the block in IDLE with no state change; abort wins.
REQ-036 err_count SHALL saturate at neither bound, since its range 0..T always fits in N_IN+1 bits.
REQ-037 Results (captured, fail_mask, err_count, pass) SHALL hold in IDLE until the next accepted start.

Reset
REQ-038 rst_n=0 at a clock edge SHALL force IDLE with abc, busy, done, pass, captured, fail_mask, err_count, idx and cnt all 0, and the latched expected/settle cleared.
REQ-039 Reset SHALL override start and abort, including mid-sweep; there is no done pulse and no partial result is retained.

Verification
REQ-040 Parity DUT model (dut_y=A^B^C), expected=8'h96, settle=0, start pulse -> abc steps 0..7 with 2 cycles each, done at edge 17, captured=8'h96, fail_mask=0, err_count=0, pass=1.
REQ-041 dut_y stuck at 0, expected=8'h96 -> fail_mask=8'h96, err_count=4, pass=0, single done pulse.
REQ-042 settle=3 -> each abc value held 5 cycles, done at edge 41, and sampling occurs only on the 5th cycle of each vector.
REQ-043 Second start at edge 5 is ignored; abort while abc=3 -> busy=0 next edge, no done, pass=0, captured bits 0..2 valid and bits 3..7 = 0.
REQ-044 rst_n low for one edge mid-sweep -> all outputs 0 next cycle; then start and abort asserted together -> busy stays 0.
REQ-045 expected changed from 8'h96 to 8'h00 at edge 4 of a sweep with the parity DUT -> pass=1 and err_count=0.
